// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or restoring
// subtract-shift step per clock, followed by a sign-fix cycle that writes hi/lo.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] work_hi_reg, work_lo_reg, operand_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             is_div_reg, neg_q_reg, neg_r_reg, dbz_reg, done_reg;

    logic             accept, sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix, fix_hi, fix_lo;

    // Operand capture: signed ops work on magnitudes and remember the signs.
    always_comb begin
        accept = (state_reg == IDLE) && start && !op[2];
        sign_a = op[0] & a[WIDTH-1];
        sign_b = op[0] & b[WIDTH-1];
        mag_a  = sign_a ? (WIDTH'(0) - a) : a;
        mag_b  = sign_b ? (WIDTH'(0) - b) : b;
    end

    // Mult keeps the multiplier in work_lo and shifts the product in from the top;
    // div keeps the dividend in work_lo and shifts quotient bits in from the bottom.
    always_comb begin
        mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : '0);
        div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, operand_reg};
        div_ok    = ~div_diff[WIDTH+1];
    end

    always_comb begin
        prod     = {work_hi_reg, work_lo_reg};
        prod_fix = neg_q_reg ? ((2*WIDTH)'(0) - prod) : prod;
        quot_fix = dbz_reg ? '1 : (neg_q_reg ? (WIDTH'(0) - work_lo_reg) : work_lo_reg);
        // With a zero divisor the remainder path reproduces |a|, so re-signing gives a back.
        rem_fix  = neg_r_reg ? (WIDTH'(0) - work_hi_reg) : work_hi_reg;
        fix_hi   = is_div_reg ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = is_div_reg ? quot_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count_reg == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = done_reg;
        hi   = hi_reg;
        lo   = lo_reg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg   <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            operand_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dbz_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    if (accept) begin
                        is_div_reg  <= op[1];
                        neg_q_reg   <= sign_a ^ sign_b;
                        neg_r_reg   <= sign_a;
                        dbz_reg     <= op[1] && (b == '0);
                        work_hi_reg <= '0;
                        work_lo_reg <= op[1] ? mag_a : mag_b;
                        operand_reg <= op[1] ? mag_b : mag_a;
                    end else if (start && op == 3'b100) begin
                        hi_reg <= a;
                    end else if (start && op == 3'b101) begin
                        lo_reg <= a;
                    end
                end
                RUN: begin
                    count_reg <= count_reg + CW'(1);
                    if (is_div_reg) begin
                        work_hi_reg <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        work_lo_reg <= {work_lo_reg[WIDTH-2:0], div_ok};
                    end else begin
                        work_hi_reg <= mul_sum[WIDTH:1];
                        work_lo_reg <= {mul_sum[0], work_lo_reg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_reg <= fix_hi;
                    lo_reg <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: MTHI/MTLO, signed/unsigned mult/div, divide-by-zero,
// signed overflow, latency, reset abort and starts ignored while busy.
module tb_md_unit;
    logic        clock = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Issue one start at the next rising edge, then release start.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clock);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Run a mult/div, scrambling a/b/op during RUN, and check latency, done and results.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  busy_cycles = 0;
        bit  seen_done = 0;
        bit  overlap = 0;
        issue(o, va, vb);
        for (int i = 0; i < 100 && !seen_done; i++) begin
            @(negedge clock);
            if (busy && done) overlap = 1;
            if (done) seen_done = 1;
            else if (busy) busy_cycles++;
            a = $urandom; b = $urandom; op = 3'($urandom_range(0, 3));
        end
        check_eq({tag, " done_seen"}, 32'(seen_done), 32'd1);
        check_eq({tag, " busy_cycles"}, busy_cycles, 32'd33);
        check_eq({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
        check_eq({tag, " hi"}, hi, exp_hi);
        check_eq({tag, " lo"}, lo, exp_lo);
        @(negedge clock);
        check_eq({tag, " done_pulse_ends"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_count;
        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_eq("reset hi", hi, 32'h0);
        check_eq("reset lo", lo, 32'h0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);

        issue(3'b100, 32'h1234_5678, 32'h0);
        check_eq("mthi hi", hi, 32'h1234_5678);
        check_eq("mthi busy", 32'(busy), 32'd0);
        check_eq("mthi done", 32'(done), 32'd0);
        issue(3'b110, 32'hAAAA_AAAA, 32'h0);
        check_eq("reserved busy", 32'(busy), 32'd0);
        check_eq("reserved hi", hi, 32'h1234_5678);

        run_op("multu max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3*7", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div -7/2", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 100/7", 3'b010, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu by0", 3'b010, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF);
        run_op("div by0", 3'b011, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Reset partway through a multiply aborts it without a hi/lo write.
        issue(3'b000, 32'd1000, 32'd1000);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort hi", hi, 32'h0);
        check_eq("abort lo", lo, 32'h0);
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) done_count++;
        end
        check_eq("abort no done", done_count, 32'd0);

        // MTLO while busy is dropped; the multiply result lands normally.
        issue(3'b000, 32'd3, 32'd5);
        repeat (5) @(negedge clock);
        start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
        @(posedge clock);
        #1 start = 1'b0;
        check_eq("busy mtlo lo", lo, 32'h0);
        done_count = 0;
        for (int i = 0; i < 60 && done_count == 0; i++) begin
            @(negedge clock);
            if (done) done_count++;
        end
        check_eq("busy mtlo done", done_count, 32'd1);
        check_eq("busy mtlo final lo", lo, 32'd15);
        check_eq("busy mtlo final hi", hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
